// File: rtl/conv_pkg.sv
// Shared constants and types for the layer-0 convolution datapath.
// The MAC stage imports this package so both ends unpack win_data identically.
package conv_pkg;

  localparam int IMG_W = 64;  // image width in pixels (power of 2)
  localparam int IMG_H = 64;  // image height in pixels
  localparam int DW    = 20;  // pixel width, signed Q4.16
  localparam int AW    = 12;  // image address width

  // Window element indices: element k sits at win_data[k*DW +: DW]
  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    SCAN  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of delay: dout is the value written DEPTH enables earlier.
// Circular store; contents are never reset because stale rows are masked
// by the window generator.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = IMG_W,
  parameter int WIDTH = DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;

  // Oldest entry is read at the slot about to be overwritten
  assign dout = mem_q[ptr_q];

  // Advance the circular pointer once per accepted pixel
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  // Write the incoming pixel into the slot just read
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streams the image once in raster order and emits every zero-padded 3x3
// neighbourhood in raster order of its centre pixel.
//
// Stream model: positions (row,col) run over the image, then over one
// virtual zero row (row IMG_H) and finally position (IMG_H+1, 0). Consuming
// position (R,C) emits centre (R-1,C-1) when C>0, or centre (R-2,IMG_W-1)
// when C==0 (right pad column). Padding is applied by masking.
//
// Handshake: a window transfers on a rising edge where win_valid=1 and
// win_ready=1. win_valid is registered and never looks at win_ready; while
// it is high and win_ready is low, win_data/win_addr/iaddr hold and no pixel
// is consumed.
module conv_window_gen
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic [AW-1:0]   iaddr,
  input  logic [DW-1:0]   idata,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [AW-1:0]   win_addr,
  output logic            done,
  output state_e          dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H) + 1;  // reaches IMG_H+1

  state_e            state_q;
  logic              busy_q, done_q, win_valid_q;
  logic [AW-1:0]     iaddr_q, win_addr_q, win_addr_d;
  logic [9*DW-1:0]   win_data_q, win_data_d;
  logic [RW-1:0]     row_q, cen_row;
  logic [CW-1:0]     col_q, cen_col;
  logic [DW-1:0]     a_q [3];   // column c-2 of the window rows
  logic [DW-1:0]     b_q [3];   // column c-1 of the window rows
  logic [DW-1:0]     newcol [3];
  logic [DW-1:0]     in_pix, lb1_out, lb2_out;
  logic              flush_end, stream_avail, out_free, consume, emit;
  logic              mask_top, mask_left, mask_right;

  assign busy      = busy_q;
  assign done      = done_q;
  assign iaddr     = iaddr_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_addr  = win_addr_q;
  assign dbg_state = state_q;

  // Row r-1 and row r-2 stores, fed by the pixel stream
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb1 (
    .clk(clk), .reset(reset), .en(consume), .din(in_pix), .dout(lb1_out)
  );
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb2 (
    .clk(clk), .reset(reset), .en(consume), .din(lb1_out), .dout(lb2_out)
  );

  // Stream control, padding masks and next window assembly
  always_comb begin
    in_pix       = (state_q == SCAN) ? idata : '0;
    newcol[0]    = lb2_out;
    newcol[1]    = lb1_out;
    newcol[2]    = in_pix;
    flush_end    = (row_q == RW'(IMG_H + 1)) && (col_q != '0);
    stream_avail = (state_q == SCAN) || ((state_q == FLUSH) && !flush_end);
    out_free     = !win_valid_q || win_ready;
    consume      = stream_avail && out_free;
    emit         = (col_q != '0) ? (row_q >= RW'(1)) : (row_q >= RW'(2));
    mask_top     = (col_q != '0) ? (row_q == RW'(1)) : (row_q == RW'(2));
    mask_left    = (col_q == CW'(1));
    mask_right   = (col_q == '0);
    cen_row      = (col_q == '0) ? row_q - RW'(2) : row_q - RW'(1);
    cen_col      = (col_q == '0) ? CW'(IMG_W - 1) : col_q - CW'(1);
    win_addr_d   = AW'(cen_row) * AW'(IMG_W) + AW'(cen_col);
    win_data_d   = '0;
    for (int dr = 0; dr < 3; dr++) begin
      win_data_d[(dr*3+TL)*DW +: DW] =
        (((dr == 0) && mask_top) || mask_left) ? '0 : a_q[dr];
      win_data_d[(dr*3+TC)*DW +: DW] =
        ((dr == 0) && mask_top) ? '0 : b_q[dr];
      win_data_d[(dr*3+TR)*DW +: DW] =
        (((dr == 0) && mask_top) || mask_right) ? '0 : newcol[dr];
    end
  end

  // Window column shift; stale contents are always masked, so no reset
  always_ff @(posedge clk) begin
    if (consume) begin
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= b_q[i];
        b_q[i] <= newcol[i];
      end
    end
  end

  // Scan FSM, stream position counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      iaddr_q     <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_addr_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (win_valid_q && win_ready) begin
        win_valid_q <= 1'b0;
      end
      if (consume) begin
        if (col_q == CW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (emit) begin
          win_valid_q <= 1'b1;
          win_data_q  <= win_data_d;
          win_addr_q  <= win_addr_d;
        end
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= PRIME;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        PRIME: begin
          iaddr_q <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (consume) begin
            if (iaddr_q == AW'(IMG_W * IMG_H - 1)) begin
              state_q <= FLUSH;
            end else begin
              iaddr_q <= iaddr_q + AW'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_end && out_free) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: image memory model, directed scans, a golden
// window model computed from the image array, and a scoreboard of expected
// (address, window) pairs checked on every transfer.
module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int WW   = 9 * DW;
  localparam int EW   = AW + WW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          win_ready = 1'b0;
  logic          busy, win_valid, done;
  logic [AW-1:0] iaddr, win_addr;
  logic [DW-1:0] idata;
  logic [WW-1:0] win_data;
  state_e        dbg_state;

  logic [DW-1:0] img [NPIX];
  logic [EW-1:0] exp_q[$];

  int cmp_cnt = 0;
  int err_cnt = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int cyc;
  int n;
  logic [WW-1:0] cap0, cap63, cap65, cap4095;

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  assign idata = img[iaddr];

  conv_window_gen dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .iaddr(iaddr),
    .idata(idata), .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_addr(win_addr), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] pack9(input int e [9]);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(e[k]);
    return w;
  endfunction

  // Golden window: element (dr,dc) = pixel(r+dr-1, c+dc-1) or 0 outside
  function automatic logic [WW-1:0] golden(input int a);
    int r, c, rr, cc;
    logic [WW-1:0] w;
    r = a / IMG_W;
    c = a % IMG_W;
    w = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
          w[(dr*3+dc)*DW +: DW] = img[rr*IMG_W + cc];
      end
    end
    return w;
  endfunction

  task automatic load_exp();
    exp_q.delete();
    for (int a = 0; a < NPIX; a++) exp_q.push_back({AW'(a), golden(a)});
    xfer_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_iaddr"}, iaddr, 0);
    chk({tag, "_valid"}, win_valid, 0);
    chk({tag, "_data"}, win_data, 0);
    chk({tag, "_waddr"}, win_addr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready low one cycle in four
  task automatic wait_done(input int budget, input int mode, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      win_ready = (mode == 1) ? ((cycles % 4) != 3) : 1'b1;
      tick();
      cycles++;
    end
    chk("done_within_budget", done, 1);
    win_ready = 1'b1;
  endtask

  task automatic end_of_scan(input string tag);
    chk({tag, "_busy_at_done"}, busy, 0);
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
    repeat (3) tick();
    chk({tag, "_transfers"}, xfer_cnt, NPIX);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, win_valid, 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset && done) done_cnt++;
    if (reset && win_valid && win_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL extra_window: got addr %0d want none", win_addr);
      end else begin
        e = exp_q.pop_front();
        chk("win_addr", win_addr, e[EW-1 -: AW]);
        chk("win_data", win_data, e[WW-1:0]);
      end
      if (win_addr == AW'(0))    cap0    = win_data;
      if (win_addr == AW'(63))   cap63   = win_data;
      if (win_addr == AW'(65))   cap65   = win_data;
      if (win_addr == AW'(4095)) cap4095 = win_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Scan 1: pixel[a]=a, no stalls
    for (int a = 0; a < NPIX; a++) img[a] = DW'(a);
    chk("model_w0", golden(0), pack9('{0, 0, 0, 0, 0, 1, 0, 64, 65}));
    chk("model_w4095", golden(4095), pack9('{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0}));
    load_exp();
    win_ready = 1'b1;
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_done(6000, 0, cyc);
    chk("start_to_done_le_4232", cyc <= IMG_W*IMG_H + 2*IMG_W + 8, 1);
    end_of_scan("scan1");
    chk("lit_w0", cap0, pack9('{0, 0, 0, 0, 0, 1, 0, 64, 65}));
    chk("lit_w65", cap65, pack9('{0, 1, 2, 64, 65, 66, 128, 129, 130}));
    chk("lit_w63", cap63, pack9('{0, 0, 0, 62, 63, 0, 126, 127, 0}));
    chk("lit_w4095", cap4095, pack9('{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0}));

    // Scan 2: 10-cycle stall on window 100, then patterned backpressure
    load_exp();
    pulse_start();
    n = 0;
    while (!(win_valid && win_addr == AW'(100)) && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_window_100", win_valid && win_addr == AW'(100), 1);
    win_ready = 1'b0;
    repeat (10) begin
      tick();
      chk("stall_valid", win_valid, 1);
      chk("stall_addr", win_addr, 100);
      chk("stall_data", win_data, pack9('{35, 36, 37, 99, 100, 101, 163, 164, 165}));
      chk("stall_iaddr", iaddr, 100 + IMG_W + 2);
    end
    win_ready = 1'b1;
    wait_done(9000, 1, cyc);
    end_of_scan("scan2");

    // Scan 3: reset (with start held) at window 2000, then rescan
    load_exp();
    pulse_start();
    n = 0;
    while (!(win_valid && win_addr == AW'(2000)) && n < 3000) begin
      tick();
      n++;
    end
    chk("reach_window_2000", win_valid && win_addr == AW'(2000), 1);
    reset = 1'b0;
    start = 1'b1;
    tick();
    chk_zero("midscan_reset");
    reset = 1'b1;
    start = 1'b0;
    tick();
    chk("reset_beats_start", busy, 0);
    load_exp();
    cap0 = '0;
    pulse_start();
    wait_done(6000, 0, cyc);
    end_of_scan("scan3");
    chk("lit_w0_after_reset", cap0, pack9('{0, 0, 0, 0, 0, 1, 0, 64, 65}));

    // Scan 4: negative pixels, start pulsed while busy and in DONE
    for (int a = 0; a < NPIX; a++) img[a] = DW'(32'h80000 | a);
    load_exp();
    pulse_start();
    repeat (50) tick();
    pulse_start();
    repeat (2000) tick();
    pulse_start();
    wait_done(6000, 0, cyc);
    start = 1'b1;  // lands on the DONE cycle
    tick();
    start = 1'b0;
    chk("neg_done_start_ignored", busy, 0);
    repeat (5) tick();
    chk("neg_transfers", xfer_cnt, NPIX);
    chk("neg_done_pulses", done_cnt, 1);
    chk("neg_queue_empty", exp_q.size(), 0);
    chk("neg_stay_idle", dbg_state, IDLE);
    chk("neg_no_rescan", busy, 0);
    chk("neg_lit_w0", cap0,
        pack9('{0, 0, 0, 0, 32'h80000, 32'h80001, 0, 32'h80040, 32'h80041}));
    chk("neg_lit_w4095", cap4095,
        pack9('{32'h80FBE, 32'h80FBF, 0, 32'h80FFE, 32'h80FFF, 0, 0, 0, 0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
